// File: rtl/fetch_decode_ctrl_if.sv
// Instruction-memory fetch bus: the sequencer drives req/addr, memory answers with ack/rdata.
interface fetch_decode_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_addr, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ack);
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: fetches the word at pc, waits for the datapath,
// then hands branch/jump decode back to the PC logic with a one-cycle pc_en.
// A fetch that sees no ack for TIMEOUT cycles parks the block in ERROR.
module fetch_decode_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_ctrl_if.master  mem,
  input  logic [31:0]          pc_i,
  input  logic                 exec_done_i,
  input  logic                 zero_i,
  output logic [31:0]          instr_o,
  output logic                 instr_valid_o,
  output logic                 pc_en_o,
  output logic [31:0]          branch_offset_o,
  output logic                 pcsel_o,
  output logic                 jump_o,
  output logic [25:0]          jump_target_o,
  output logic                 fetch_err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_START  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic          pcsel_q, pcsel_d;
  logic          jump_q, jump_d;
  logic [5:0]    op;

  assign op = instr_q[31:26];

  // Next-state logic; ack on the last allowed fetch cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pcsel_d = pcsel_q;
    jump_d  = jump_q;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // zero is only meaningful alongside exec_done, so decode is latched here
        if (exec_done_i) begin
          pcsel_d = ((op == 6'h04) & zero_i) | ((op == 6'h05) & ~zero_i);
          jump_d  = (op == 6'h02) | (op == 6'h03);
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_START;
    endcase
  end

  // State registers with synchronous reset; reset abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_START;
      cnt_q   <= '0;
      instr_q <= '0;
      pcsel_q <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pcsel_q <= pcsel_d;
      jump_q  <= jump_d;
    end
  end

  // Strobes decode straight from the state register, so each lasts exactly one state.
  assign mem.mem_req      = (state_q == S_FETCH);
  assign mem.mem_addr     = (state_q == S_FETCH) ? pc_i : 32'h0;
  assign instr_o          = instr_q;
  assign instr_valid_o    = (state_q == S_DECODE);
  assign pc_en_o          = (state_q == S_UPDATE);
  assign pcsel_o          = (state_q == S_UPDATE) & pcsel_q;
  assign jump_o           = (state_q == S_UPDATE) & jump_q;
  assign fetch_err_o      = (state_q == S_ERROR);
  assign branch_offset_o  = {{16{instr_q[15]}}, instr_q[15:0]};
  assign jump_target_o    = instr_q[25:0];

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: table of instructions run through full
// fetch/decode/exec/update cycles, plus reset and timeout sequences.
module tb_fetch_decode_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_i = 32'h0;
  logic        exec_done_i = 1'b0;
  logic        zero_i = 1'b0;
  logic [31:0] instr_o, branch_offset_o;
  logic        instr_valid_o, pc_en_o, pcsel_o, jump_o, fetch_err_o;
  logic [25:0] jump_target_o;

  int errors = 0;
  int checks = 0;

  fetch_decode_ctrl_if mif ();

  fetch_decode_ctrl #(.TIMEOUT(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem             (mif),
    .pc_i            (pc_i),
    .exec_done_i     (exec_done_i),
    .zero_i          (zero_i),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o),
    .pc_en_o         (pc_en_o),
    .branch_offset_o (branch_offset_o),
    .pcsel_o         (pcsel_o),
    .jump_o          (jump_o),
    .jump_target_o   (jump_target_o),
    .fetch_err_o     (fetch_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          ack_wait;
    int          exec_wait;
    bit          stray;
    logic        exp_pcsel;
    logic        exp_jump;
    logic [31:0] exp_boff;
    logic [25:0] exp_jt;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(mif.mem_req), 32'h0);
    chk({tag, "_addr"},  mif.mem_addr, 32'h0);
    chk({tag, "_instr"}, instr_o, 32'h0);
    chk({tag, "_ival"},  32'(instr_valid_o), 32'h0);
    chk({tag, "_pcen"},  32'(pc_en_o), 32'h0);
    chk({tag, "_boff"},  branch_offset_o, 32'h0);
    chk({tag, "_pcsel"}, 32'(pcsel_o), 32'h0);
    chk({tag, "_jump"},  32'(jump_o), 32'h0);
    chk({tag, "_jt"},    32'(jump_target_o), 32'h0);
    chk({tag, "_err"},   32'(fetch_err_o), 32'h0);
  endtask

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;

    //          instr         zero  ackw execw stray pcsel jump boff          jt
    vecs[0] = '{32'h012A4020, 1'b0, 0,   0,    1'b0, 1'b0, 1'b0, 32'h00004020, 26'h12A4020};
    vecs[1] = '{32'h1109FFFC, 1'b1, 0,   0,    1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 26'h109FFFC};
    vecs[2] = '{32'h1509FFFC, 1'b1, 0,   0,    1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 26'h109FFFC};
    vecs[3] = '{32'h08000010, 1'b1, 0,   0,    1'b0, 1'b0, 1'b1, 32'h00000010, 26'h0000010};
    vecs[4] = '{32'h1509FFFC, 1'b0, 3,   2,    1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 26'h109FFFC};
    vecs[5] = '{32'h0C000123, 1'b1, 1,   1,    1'b1, 1'b0, 1'b1, 32'h00000123, 26'h0000123};
    vecs[6] = '{32'h1109FFFC, 1'b0, 14,  0,    1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 26'h109FFFC};
    vecs[7] = '{32'h00008000, 1'b1, 0,   0,    1'b0, 1'b0, 1'b0, 32'hFFFF8000, 26'h0008000};

    // reset for 3 cycles, then one START cycle before the first request
    tick(); tick();
    chk_reset_vals("rst");
    tick();
    reset = 1'b0;
    chk("start_req", 32'(mif.mem_req), 32'h0);
    tick();

    foreach (vecs[k]) begin
      vec_t v;
      v = vecs[k];
      chk("fetch_req",   32'(mif.mem_req), 32'h1);
      chk("fetch_addr",  mif.mem_addr, pc_i);
      chk("fetch_pcen",  32'(pc_en_o), 32'h0);
      chk("fetch_pcsel", 32'(pcsel_o), 32'h0);
      chk("fetch_jump",  32'(jump_o), 32'h0);
      for (int w = 0; w < v.ack_wait; w++) begin
        exec_done_i = v.stray;
        tick();
        chk("wait_req", 32'(mif.mem_req), 32'h1);
        chk("wait_err", 32'(fetch_err_o), 32'h0);
      end
      exec_done_i   = 1'b0;
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = v.instr;
      tick();
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 32'hA5A5A5A5;
      chk("dec_ival",  32'(instr_valid_o), 32'h1);
      chk("dec_instr", instr_o, v.instr);
      chk("dec_boff",  branch_offset_o, v.exp_boff);
      chk("dec_jt",    32'(jump_target_o), 32'(v.exp_jt));
      chk("dec_req",   32'(mif.mem_req), 32'h0);
      chk("dec_addr",  mif.mem_addr, 32'h0);
      chk("dec_pcen",  32'(pc_en_o), 32'h0);
      chk("dec_pcsel", 32'(pcsel_o), 32'h0);
      chk("dec_jump",  32'(jump_o), 32'h0);
      chk("dec_err",   32'(fetch_err_o), 32'h0);
      mif.mem_ack = v.stray;
      tick();
      mif.mem_ack = 1'b0;
      chk("exec_ival",  32'(instr_valid_o), 32'h0);
      chk("exec_pcen",  32'(pc_en_o), 32'h0);
      chk("exec_instr", instr_o, v.instr);
      for (int w = 0; w < v.exec_wait; w++) begin
        mif.mem_ack = v.stray;
        zero_i      = ~v.zero;
        tick();
        mif.mem_ack = 1'b0;
        chk("ewait_pcen",  32'(pc_en_o), 32'h0);
        chk("ewait_req",   32'(mif.mem_req), 32'h0);
        chk("ewait_ival",  32'(instr_valid_o), 32'h0);
        chk("ewait_instr", instr_o, v.instr);
      end
      zero_i      = v.zero;
      exec_done_i = 1'b1;
      tick();
      exec_done_i = 1'b0;
      zero_i      = ~v.zero;
      chk("upd_pcen",  32'(pc_en_o), 32'h1);
      chk("upd_pcsel", 32'(pcsel_o), 32'(v.exp_pcsel));
      chk("upd_jump",  32'(jump_o), 32'(v.exp_jump));
      chk("upd_req",   32'(mif.mem_req), 32'h0);
      chk("upd_boff",  branch_offset_o, v.exp_boff);
      pc_i = pc_i + 32'h11;
      tick();
    end

    // reset while in EXEC with exec_done pending
    chk("rx_req", 32'(mif.mem_req), 32'h1);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h1109FFFC;
    tick();
    mif.mem_ack = 1'b0;
    tick();
    chk("rx_exec_ival", 32'(instr_valid_o), 32'h0);
    reset       = 1'b1;
    exec_done_i = 1'b1;
    zero_i      = 1'b1;
    tick();
    exec_done_i = 1'b0;
    chk_reset_vals("rexec");
    reset = 1'b0;
    pc_i  = 32'h00000ABC;
    tick();
    chk("rexec_req",  32'(mif.mem_req), 32'h1);
    chk("rexec_addr", mif.mem_addr, 32'h00000ABC);

    // reset during a fetch wait, coinciding with an ack that must be dropped
    for (int w = 0; w < 5; w++) tick();
    chk("rf_req", 32'(mif.mem_req), 32'h1);
    reset         = 1'b1;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hDEADBEEF;
    tick();
    mif.mem_ack = 1'b0;
    chk_reset_vals("rfetch");
    reset = 1'b0;
    pc_i  = 32'h00000040;
    tick();
    chk("rfetch_req",  32'(mif.mem_req), 32'h1);
    chk("rfetch_addr", mif.mem_addr, 32'h00000040);

    // timeout: request stays high exactly 15 cycles, then sticky error
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk($sformatf("to_req%0d", c), 32'(mif.mem_req), 32'h1);
      chk($sformatf("to_err%0d", c), 32'(fetch_err_o), 32'h0);
    end
    tick();
    chk("to_err",  32'(fetch_err_o), 32'h1);
    chk("to_req",  32'(mif.mem_req), 32'h0);
    chk("to_addr", mif.mem_addr, 32'h0);
    for (int c = 0; c < 4; c++) begin
      mif.mem_ack = 1'b1;
      exec_done_i = 1'b1;
      tick();
      chk("sticky_err",  32'(fetch_err_o), 32'h1);
      chk("sticky_req",  32'(mif.mem_req), 32'h0);
      chk("sticky_pcen", 32'(pc_en_o), 32'h0);
      chk("sticky_ival", 32'(instr_valid_o), 32'h0);
    end
    mif.mem_ack = 1'b0;
    exec_done_i = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_vals("rerr");
    reset = 1'b0;
    tick();
    chk("rerr_req",  32'(mif.mem_req), 32'h1);
    chk("rerr_addr", mif.mem_addr, pc_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // pcsel and jump are mutually exclusive at all times
  always @(negedge clk) begin
    if (!reset && pcsel_o && jump_o) begin
      errors++;
      $display("FAIL excl: pcsel=%b jump=%b both set at %0t", pcsel_o, jump_o, $time);
    end
  end

endmodule
